// File: rtl/stopwatch_counter.sv
// Purpose : mm:ss BCD stopwatch with run / pause / field-adjust modes.
// Latency : 1 cycle from a qualifying tick or pause pulse to the registered digits.
// Backpr. : none; ticks and pulses are one-cycle strobes, consumed or ignored on the edge they arrive.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset -> 00:00, paused
//   tick1hz      1 Hz strobe, advances time by one second in RUN
//   tick2hz      2 Hz strobe, steps the selected field in ADJUST
//   pause_pulse  debounced strobe, toggles paused when adj=0
//   adj          level, 1 = ADJUST mode
//   sel          level, adjust field: 0 = minutes, 1 = seconds
//   digit1..4    m10, m1, s10, s1 as {1'b0, BCD}
//   running      registered ~adj & ~paused
//   adjusting    registered adj
module stopwatch_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick1hz,
    input  logic       tick2hz,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [4:0] digit1,
    output logic [4:0] digit2,
    output logic [4:0] digit3,
    output logic [4:0] digit4,
    output logic       running,
    output logic       adjusting
);

    localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

    localparam logic [1:0] MODE_PAUSE  = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_ADJUST = 2'd2;

    logic [3:0] m10_q, m10_d;
    logic [3:0] m1_q,  m1_d;
    logic [3:0] s10_q, s10_d;
    logic [3:0] s1_q,  s1_d;
    logic       paused_q, paused_d;
    logic       running_q, running_d;
    logic       adjusting_q, adjusting_d;

    logic [1:0] mode;
    logic       min_at_max;
    logic       sec_at_max;

    // Mode is decided from the live adj level and the stored paused flag,
    // so a change of adj acts on the very next edge.
    always_comb begin
        if (adj)
            mode = MODE_ADJUST;
        else if (!paused_q)
            mode = MODE_RUN;
        else
            mode = MODE_PAUSE;
    end

    // ">=" rather than "==" so an out-of-range minute value can never stick.
    assign min_at_max = (m10_q > MAX_TENS) ||
                        ((m10_q == MAX_TENS) && (m1_q >= MAX_ONES));
    assign sec_at_max = (s10_q >= 4'd5) && (s1_q >= 4'd9);

    always_comb begin
        m10_d     = m10_q;
        m1_d      = m1_q;
        s10_d     = s10_q;
        s1_d      = s1_q;
        paused_d  = paused_q;

        case (mode)
            MODE_RUN: begin
                if (tick1hz) begin
                    if (s1_q < 4'd9) begin
                        s1_d = s1_q + 4'd1;
                    end else begin
                        s1_d = 4'd0;
                        if (s10_q < 4'd5) begin
                            s10_d = s10_q + 4'd1;
                        end else begin
                            s10_d = 4'd0;
                            if (min_at_max) begin
                                m10_d = 4'd0;
                                m1_d  = 4'd0;
                            end else if (m1_q < 4'd9) begin
                                m1_d = m1_q + 4'd1;
                            end else begin
                                m1_d  = 4'd0;
                                m10_d = m10_q + 4'd1;
                            end
                        end
                    end
                end
            end
            MODE_ADJUST: begin
                // Fields step independently: no carry from seconds to minutes.
                if (tick2hz) begin
                    if (sel) begin
                        if (sec_at_max) begin
                            s10_d = 4'd0;
                            s1_d  = 4'd0;
                        end else if (s1_q < 4'd9) begin
                            s1_d = s1_q + 4'd1;
                        end else begin
                            s1_d  = 4'd0;
                            s10_d = s10_q + 4'd1;
                        end
                    end else begin
                        if (min_at_max) begin
                            m10_d = 4'd0;
                            m1_d  = 4'd0;
                        end else if (m1_q < 4'd9) begin
                            m1_d = m1_q + 4'd1;
                        end else begin
                            m1_d  = 4'd0;
                            m10_d = m10_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                // PAUSE: time holds, both ticks ignored.
            end
        endcase

        // The increment above already used the old paused flag, so a pause
        // pulse coinciding with tick1hz counts in RUN and is tick-free in PAUSE.
        if (!adj && pause_pulse)
            paused_d = ~paused_q;

        running_d   = ~adj & ~paused_d;
        adjusting_d = adj;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m10_q       <= 4'd0;
            m1_q        <= 4'd0;
            s10_q       <= 4'd0;
            s1_q        <= 4'd0;
            paused_q    <= 1'b1;
            running_q   <= 1'b0;
            adjusting_q <= 1'b0;
        end else begin
            m10_q       <= m10_d;
            m1_q        <= m1_d;
            s10_q       <= s10_d;
            s1_q        <= s1_d;
            paused_q    <= paused_d;
            running_q   <= running_d;
            adjusting_q <= adjusting_d;
        end
    end

    assign digit1    = {1'b0, m10_q};
    assign digit2    = {1'b0, m1_q};
    assign digit3    = {1'b0, s10_q};
    assign digit4    = {1'b0, s1_q};
    assign running   = running_q;
    assign adjusting = adjusting_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose : self-checking bench for stopwatch_counter against a time-in-seconds model.
// Latency : checks every output 1 ns after each rising edge.
// Backpr. : n/a.
module tb_stopwatch_counter;

    localparam int MAXM = 59;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick1hz, tick2hz, pause_pulse, adj, sel;
    logic [4:0] digit1, digit2, digit3, digit4;
    logic       running, adjusting;
    logic [19:0] dig;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integer minutes/seconds.
    int m_min, m_sec;
    bit m_paused, m_running, m_adjusting;
    string phase = "init";

    stopwatch_counter #(.MIN_MAX(MAXM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick1hz    (tick1hz),
        .tick2hz    (tick2hz),
        .pause_pulse(pause_pulse),
        .adj        (adj),
        .sel        (sel),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .running    (running),
        .adjusting  (adjusting)
    );

    always #5 clk = ~clk;

    assign dig = {digit1, digit2, digit3, digit4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int mm, input int ss);
        return {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0;
        m_paused = 1'b1; m_running = 1'b0; m_adjusting = 1'b0;
    endtask

    // One clock edge of the behavioural rules, using the inputs as sampled.
    task automatic model_step();
        int total;
        if (adj) begin
            if (tick2hz) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % (MAXM + 1);
            end
        end else begin
            if (!m_paused && tick1hz) begin
                total = (m_min * 60 + m_sec + 1) % ((MAXM + 1) * 60);
                m_min = total / 60;
                m_sec = total % 60;
            end
            if (pause_pulse) m_paused = !m_paused;
        end
        m_running   = !adj && !m_paused;
        m_adjusting = adj;
    endtask

    task automatic check_model();
        chk({phase, "_dig"}, dig, pack(m_min, m_sec));
        chk({phase, "_run"}, running, m_running);
        chk({phase, "_adj"}, adjusting, m_adjusting);
    endtask

    task automatic cyc(input bit t1, input bit t2, input bit pp);
        tick1hz = t1; tick2hz = t2; pause_pulse = pp;
        @(posedge clk);
        model_step();
        #1;
        check_model();
        tick1hz = 1'b0; tick2hz = 1'b0; pause_pulse = 1'b0;
    endtask

    // Asserted between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_dig", dig, 20'd0);
        chk("rst_async_run", running, 1'b0);
        chk("rst_async_adj", adjusting, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick1hz = 1'b0; tick2hz = 1'b0; pause_pulse = 1'b0;
        adj = 1'b0; sel = 1'b0;
        model_reset();
        #1;
        chk("por_dig", dig, 20'd0);
        chk("por_run", running, 1'b0);
        chk("por_adj", adjusting, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start from pause, 75 seconds of running.
        phase = "r027";
        cyc(0, 0, 1);
        repeat (75) cyc(1, 0, 0);
        chk("r027_value", dig, pack(1, 15));
        chk("r027_running", running, 1'b1);

        // Preload 59:58 via adjust, then roll past the top.
        phase = "r028";
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (59) cyc(0, 1, 0);
        sel = 1'b1;
        repeat (58) cyc(0, 1, 0);
        adj = 1'b0;
        cyc(0, 0, 1);
        chk("r028_preload", dig, pack(59, 58));
        cyc(1, 0, 0); chk("r028_5959", dig, pack(59, 59));
        cyc(1, 0, 0); chk("r028_0000", dig, pack(0, 0));
        cyc(1, 0, 0); chk("r028_0001", dig, pack(0, 1));

        // Paused at 12:34 ignores both ticks.
        phase = "r029";
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (12) cyc(0, 1, 0);
        sel = 1'b1;
        repeat (34) cyc(0, 1, 0);
        adj = 1'b0;
        repeat (10) cyc(1, 0, 0);
        repeat (4)  cyc(0, 1, 0);
        cyc(1, 1, 0);
        chk("r029_hold", dig, pack(12, 34));
        chk("r029_running", running, 1'b0);

        // Seconds-field wrap with no carry, then minutes full circle.
        phase = "r030";
        do_reset();
        adj = 1'b1; sel = 1'b1;
        repeat (58) cyc(0, 1, 0);
        cyc(0, 1, 0); chk("r030_0059", dig, pack(0, 59));
        cyc(0, 1, 0); chk("r030_0000", dig, pack(0, 0));
        cyc(0, 1, 0); chk("r030_0001", dig, pack(0, 1));
        cyc(1, 0, 0); chk("r030_t1_ignored", dig, pack(0, 1));
        cyc(0, 0, 1); chk("r030_pp_ignored_adj", running, 1'b0);
        sel = 1'b0;
        repeat (59) cyc(0, 1, 0);
        chk("r030_min59", dig, pack(59, 1));
        cyc(0, 1, 0);
        chk("r030_min00", dig, pack(0, 1));
        chk("r030_adjusting", adjusting, 1'b1);

        // Pause pulse coinciding with tick in RUN, then in PAUSE.
        phase = "r031";
        do_reset();
        adj = 1'b0;
        cyc(0, 0, 1);
        repeat (9) cyc(1, 0, 0);
        chk("r031_0009", dig, pack(0, 9));
        cyc(1, 0, 1);
        chk("r031_0010", dig, pack(0, 10));
        chk("r031_running", running, 1'b0);
        cyc(1, 0, 0);
        chk("r031_hold", dig, pack(0, 10));
        cyc(1, 0, 1);
        chk("r031_resume_no_inc", dig, pack(0, 10));
        chk("r031_resume_run", running, 1'b1);

        // Async reset in ADJUST at 07:07 with a tick pending.
        phase = "r032";
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (7) cyc(0, 1, 0);
        sel = 1'b1;
        repeat (7) cyc(0, 1, 0);
        chk("r032_0707", dig, pack(7, 7));
        tick2hz = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r032_dig0", dig, 20'd0);
        chk("r032_adjusting", adjusting, 1'b0);
        chk("r032_running", running, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        tick2hz = 1'b0; adj = 1'b0;
        rst_n = 1'b1;
        cyc(0, 0, 0);
        chk("r032_after_rel", dig, pack(0, 0));
        chk("r032_paused", running, 1'b0);

        // Randomised traffic, occasional mid-cycle resets.
        phase = "rand";
        adj = 1'b0; sel = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit t1, t2, pp;
            if ($urandom_range(0, 63) == 0) adj = ~adj;
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            t1 = ($urandom_range(0, 1) == 1);
            t2 = ($urandom_range(0, 2) == 0);
            pp = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else cyc(t1, t2, pp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
